// File: rtl/tlb_pkg.sv
// Shared types, constants and VA-match helper for the LoongArch TLB array.
package tlb_pkg;

  typedef struct packed {
    logic        v;
    logic        d;
    logic [1:0]  mat;
    logic [1:0]  plv;
    logic [19:0] ppn;
  } tlb_half_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic        e;
    tlb_half_t   p0;
    tlb_half_t   p1;
  } tlb_ent_t;

  localparam int unsigned TLB_ENT_W = $bits(tlb_ent_t);
  localparam logic [5:0]  PS_4K     = 6'd12;

  localparam logic [4:0] INV_OP_ALL0     = 5'd0;
  localparam logic [4:0] INV_OP_ALL1     = 5'd1;
  localparam logic [4:0] INV_OP_G        = 5'd2;
  localparam logic [4:0] INV_OP_NG       = 5'd3;
  localparam logic [4:0] INV_OP_NG_ASID  = 5'd4;
  localparam logic [4:0] INV_OP_NG_AS_VA = 5'd5;
  localparam logic [4:0] INV_OP_GA_VA    = 5'd6;
  localparam logic [4:0] INV_OP_MAX      = 5'd6;

  typedef enum logic [1:0] {
    INV_IDLE,
    INV_SWEEP,
    INV_DONE
  } inv_state_e;

  // 4K pages compare the full VPPN; anything larger compares VA[31:22] only.
  function automatic logic tlb_va_match(input logic [18:0] vppn,
                                        input logic [5:0]  ps,
                                        input logic [18:0] cmp);
    if (ps == PS_4K) return vppn == cmp;
    else             return vppn[18:9] == cmp[18:9];
  endfunction

endpackage

// File: rtl/tlb_search_port.sv
// One registered TLB search port: match, lowest-index priority, multi-hit, half select.
module tlb_search_port
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM = 32,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  tlb_ent_t        ent_i [TLBNUM],
  input  logic            req_i,
  input  logic [18:0]     vppn_i,
  input  logic            odd_i,
  input  logic [9:0]      asid_i,
  output logic            valid_o,
  output logic            found_o,
  output logic            multi_o,
  output logic [IDXW-1:0] index_o,
  output logic [5:0]      ps_o,
  output logic [19:0]     ppn_o,
  output logic            v_o,
  output logic            d_o,
  output logic [1:0]      mat_o,
  output logic [1:0]      plv_o
);

  logic            hit_d, multi_d;
  logic [IDXW-1:0] idx_d;
  tlb_ent_t        sel;
  tlb_half_t       half_d;

  logic            valid_q, found_q, multi_q;
  logic [IDXW-1:0] idx_q;
  logic [5:0]      ps_q;
  tlb_half_t       half_q;

  always_comb begin
    hit_d   = 1'b0;
    multi_d = 1'b0;
    idx_d   = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (ent_i[i].e && (ent_i[i].g || ent_i[i].asid == asid_i) &&
          tlb_va_match(ent_i[i].vppn, ent_i[i].ps, vppn_i)) begin
        if (hit_d) multi_d = 1'b1;
        else begin
          hit_d = 1'b1;
          idx_d = IDXW'(i);
        end
      end
    end
  end

  always_comb begin
    sel    = ent_i[idx_d];
    half_d = ((sel.ps == PS_4K) ? odd_i : vppn_i[8]) ? sel.p1 : sel.p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      found_q <= 1'b0;
      multi_q <= 1'b0;
      idx_q   <= '0;
      ps_q    <= '0;
      half_q  <= '0;
    end else begin
      valid_q <= req_i;
      if (req_i) begin
        found_q <= hit_d;
        multi_q <= multi_d;
        idx_q   <= hit_d ? idx_d : '0;
        ps_q    <= hit_d ? sel.ps : '0;
        half_q  <= hit_d ? half_d : '0;
      end
    end
  end

  assign valid_o = valid_q;
  assign found_o = found_q;
  assign multi_o = multi_q;
  assign index_o = idx_q;
  assign ps_o    = ps_q;
  assign ppn_o   = half_q.ppn;
  assign v_o     = half_q.v;
  assign d_o     = half_q.d;
  assign mat_o   = half_q.mat;
  assign plv_o   = half_q.plv;

endmodule

// File: rtl/tlb_array_mp.sv
// Fully-associative TLB: NPORT search ports, write/read ports, TLBFILL counter, INVTLB sweep engine.
module tlb_array_mp
  import tlb_pkg::*;
#(
  parameter  int unsigned TLBNUM      = 32,
  parameter  int unsigned NPORT       = 2,
  parameter  int unsigned INV_PER_CYC = 8,
  localparam int unsigned IDXW        = $clog2(TLBNUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      s_req,
  input  logic [NPORT*19-1:0]   s_vppn,
  input  logic [NPORT-1:0]      s_odd,
  input  logic [NPORT*10-1:0]   s_asid,
  output logic [NPORT-1:0]      s_valid,
  output logic [NPORT-1:0]      s_found,
  output logic [NPORT-1:0]      s_multi,
  output logic [NPORT*IDXW-1:0] s_index,
  output logic [NPORT*6-1:0]    s_ps,
  output logic [NPORT*20-1:0]   s_ppn,
  output logic [NPORT-1:0]      s_v,
  output logic [NPORT-1:0]      s_d,
  output logic [NPORT*2-1:0]    s_mat,
  output logic [NPORT*2-1:0]    s_plv,
  input  logic                  we,
  input  logic [IDXW-1:0]       w_index,
  input  logic [TLB_ENT_W-1:0]  w_entry,
  input  logic                  w_fill,
  output logic [IDXW-1:0]       fill_idx,
  input  logic [IDXW-1:0]       r_index,
  output logic [TLB_ENT_W-1:0]  r_entry,
  input  logic                  inv_req,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_vpn,
  output logic                  inv_busy,
  output logic                  inv_done,
  output logic                  inv_err
);

  localparam int unsigned SLICES = TLBNUM / INV_PER_CYC;
  localparam int unsigned SW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  tlb_ent_t        w_ent;
  tlb_ent_t        ent_q   [TLBNUM];
  tlb_ent_t        ent_view[TLBNUM];
  logic [TLBNUM-1:0] e_q;
  logic [TLBNUM-1:0] inv_hit;
  logic [IDXW-1:0] fill_q;

  inv_state_e      state_q, state_d;
  logic [SW-1:0]   slice_q;
  logic [4:0]      op_q;
  logic [9:0]      asid_q;
  logic [18:0]     vpn_q;
  logic            err_q;
  logic            accept;

  assign w_ent  = tlb_ent_t'(w_entry);
  assign accept = (state_q == INV_IDLE) && inv_req;

  // E lives in its own resettable vector; the rest of each entry is never reset.
  always_comb begin
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      ent_view[i]   = ent_q[i];
      ent_view[i].e = e_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (we) ent_q[w_index] <= w_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
    end else begin
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        if (we && (w_index == IDXW'(i))) e_q[i] <= w_ent.e;
        else if (inv_hit[i])             e_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              fill_q <= '0;
    else if (we && w_fill) fill_q <= fill_q + 1'b1;
  end

  assign fill_idx = fill_q;
  assign r_entry  = ent_view[r_index];

  always_comb begin
    logic g, asid_eq, va_eq, cond;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      g       = ent_q[i].g;
      asid_eq = ent_q[i].asid == asid_q;
      va_eq   = tlb_va_match(ent_q[i].vppn, ent_q[i].ps, vpn_q);
      unique case (op_q)
        INV_OP_ALL0, INV_OP_ALL1: cond = 1'b1;
        INV_OP_G:                 cond = g;
        INV_OP_NG:                cond = !g;
        INV_OP_NG_ASID:           cond = !g && asid_eq;
        INV_OP_NG_AS_VA:          cond = !g && asid_eq && va_eq;
        INV_OP_GA_VA:             cond = (g || asid_eq) && va_eq;
        default:                  cond = 1'b0;
      endcase
      inv_hit[i] = (state_q == INV_SWEEP) && (SW'(i / INV_PER_CYC) == slice_q) && cond;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= INV_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INV_IDLE:  if (inv_req) state_d = (inv_op > INV_OP_MAX) ? INV_DONE : INV_SWEEP;
      INV_SWEEP: if (slice_q == SW'(SLICES - 1)) state_d = INV_DONE;
      INV_DONE:  state_d = INV_IDLE;
      default:   state_d = INV_IDLE;
    endcase
  end

  always_comb begin
    inv_busy = (state_q != INV_IDLE);
    inv_done = (state_q == INV_DONE);
    inv_err  = (state_q == INV_DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice_q <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vpn_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      slice_q <= '0;
      op_q    <= inv_op;
      asid_q  <= inv_asid;
      vpn_q   <= inv_vpn;
      err_q   <= inv_op > INV_OP_MAX;
    end else if (state_q == INV_SWEEP) begin
      slice_q <= slice_q + 1'b1;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    tlb_search_port #(.TLBNUM(TLBNUM)) u_port (
      .clk     (clk),
      .rst     (rst),
      .ent_i   (ent_view),
      .req_i   (s_req[p]),
      .vppn_i  (s_vppn[p*19 +: 19]),
      .odd_i   (s_odd[p]),
      .asid_i  (s_asid[p*10 +: 10]),
      .valid_o (s_valid[p]),
      .found_o (s_found[p]),
      .multi_o (s_multi[p]),
      .index_o (s_index[p*IDXW +: IDXW]),
      .ps_o    (s_ps[p*6 +: 6]),
      .ppn_o   (s_ppn[p*20 +: 20]),
      .v_o     (s_v[p]),
      .d_o     (s_d[p]),
      .mat_o   (s_mat[p*2 +: 2]),
      .plv_o   (s_plv[p*2 +: 2])
    );
  end

endmodule

// File: tb/tb_tlb_array_mp.sv
// Directed self-checking bench for tlb_array_mp (TLBNUM=32, NPORT=2, INV_PER_CYC=8).
module tb_tlb_array_mp;
  import tlb_pkg::*;

  localparam int unsigned TLBNUM = 32;
  localparam int unsigned NPORT  = 2;
  localparam int unsigned IPC    = 8;
  localparam int unsigned IDXW   = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NPORT-1:0]      s_req;
  logic [NPORT*19-1:0]   s_vppn;
  logic [NPORT-1:0]      s_odd;
  logic [NPORT*10-1:0]   s_asid;
  logic [NPORT-1:0]      s_valid, s_found, s_multi, s_v, s_d;
  logic [NPORT*IDXW-1:0] s_index;
  logic [NPORT*6-1:0]    s_ps;
  logic [NPORT*20-1:0]   s_ppn;
  logic [NPORT*2-1:0]    s_mat, s_plv;
  logic                  we, w_fill;
  logic [IDXW-1:0]       w_index, fill_idx, r_index;
  logic [TLB_ENT_W-1:0]  w_entry, r_entry;
  logic                  inv_req, inv_busy, inv_done, inv_err;
  logic [4:0]            inv_op;
  logic [9:0]            inv_asid;
  logic [18:0]           inv_vpn;

  int n_checks = 0;
  int n_fail   = 0;
  tlb_ent_t rd;

  tlb_array_mp #(.TLBNUM(TLBNUM), .NPORT(NPORT), .INV_PER_CYC(IPC)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_vppn(s_vppn), .s_odd(s_odd), .s_asid(s_asid),
    .s_valid(s_valid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
    .s_ps(s_ps), .s_ppn(s_ppn), .s_v(s_v), .s_d(s_d), .s_mat(s_mat), .s_plv(s_plv),
    .we(we), .w_index(w_index), .w_entry(w_entry), .w_fill(w_fill), .fill_idx(fill_idx),
    .r_index(r_index), .r_entry(r_entry),
    .inv_req(inv_req), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
    .inv_busy(inv_busy), .inv_done(inv_done), .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_ent_t make_ent(input logic [18:0] vppn, input logic [9:0] asid,
                                        input logic g, input logic [5:0] ps, input logic e,
                                        input logic [19:0] ppn0, input logic [19:0] ppn1);
    tlb_ent_t t;
    t.vppn = vppn; t.asid = asid; t.g = g; t.ps = ps; t.e = e;
    t.p0 = '{v: 1'b1, d: 1'b1, mat: 2'd1, plv: 2'd0, ppn: ppn0};
    t.p1 = '{v: 1'b1, d: 1'b0, mat: 2'd1, plv: 2'd3, ppn: ppn1};
    return t;
  endfunction

  task automatic write_ent(input logic [IDXW-1:0] idx, input tlb_ent_t t, input logic fill);
    we = 1'b1; w_index = idx; w_entry = t; w_fill = fill;
    tick();
    we = 1'b0; w_fill = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [18:0] vppn, input logic odd, input logic [9:0] asid);
    s_req[p] = 1'b1;
    s_vppn[p*19 +: 19] = vppn;
    s_odd[p] = odd;
    s_asid[p*10 +: 10] = asid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (fill_idx !== 5'd0) begin n_fail++; $display("FAIL reset_fill_idx got %0d want 0", fill_idx); end
    n_checks++;
    if ({s_valid, s_found, inv_busy, inv_done, inv_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs got valid=%b found=%b busy=%b done=%b err=%b want all 0",
                         s_valid, s_found, inv_busy, inv_done, inv_err);
    end
    set_port(0, 19'h12345, 1'b0, 10'd3);
    set_port(1, 19'h00000, 1'b1, 10'd0);
    tick();
    s_req = '0;
    n_checks++;
    if (s_valid !== 2'b11 || s_found !== 2'b00 || s_index !== 10'd0) begin
      n_fail++; $display("FAIL reset_search_miss got valid=%b found=%b index=%h want 11 00 000",
                         s_valid, s_found, s_index);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 30; i++) write_ent(fill_idx, make_ent(19'h0, 10'd0, 1'b0, PS_4K, 1'b0, 20'h0, 20'h0), 1'b1);
    n_checks++;
    if (fill_idx !== 5'd30) begin n_fail++; $display("FAIL fill_reach30 got %0d want 30", fill_idx); end
    write_ent(5'd3, make_ent(19'h0, 10'd0, 1'b0, PS_4K, 1'b0, 20'h0, 20'h0), 1'b0);
    n_checks++;
    if (fill_idx !== 5'd30) begin n_fail++; $display("FAIL fill_nofill_hold got %0d want 30", fill_idx); end
    for (int i = 0; i < 4; i++) begin
      logic [IDXW-1:0] exp;
      exp = IDXW'(31 + i);
      write_ent(fill_idx, make_ent(19'h0, 10'd0, 1'b0, PS_4K, 1'b0, 20'h0, 20'h0), 1'b1);
      n_checks++;
      if (fill_idx !== exp) begin n_fail++; $display("FAIL fill_wrap step %0d got %0d want %0d", i, fill_idx, exp); end
    end
  endtask

  task automatic test_basic_hit();
    write_ent(5'd5, make_ent(19'h12345, 10'd3, 1'b0, PS_4K, 1'b1, 20'hA, 20'hB), 1'b0);
    set_port(0, 19'h12345, 1'b1, 10'd3);
    set_port(1, 19'h12345, 1'b1, 10'd4);
    tick();
    s_req = '0;
    n_checks++;
    if (s_valid !== 2'b11 || s_found !== 2'b01 || s_index[4:0] !== 5'd5 || s_ppn[19:0] !== 20'hB ||
        s_ps[5:0] !== 6'd12 || s_multi[0] !== 1'b0 || s_plv[1:0] !== 2'd3 || s_d[0] !== 1'b0) begin
      n_fail++; $display("FAIL hit_odd got valid=%b found=%b idx=%0d ppn=%h ps=%0d multi=%b plv=%0d d=%b want 11 01 5 B 12 0 3 0",
                         s_valid, s_found, s_index[4:0], s_ppn[19:0], s_ps[5:0], s_multi[0], s_plv[1:0], s_d[0]);
    end
    n_checks++;
    if (s_index[9:5] !== 5'd0 || s_ppn[39:20] !== 20'h0 || s_ps[11:6] !== 6'd0) begin
      n_fail++; $display("FAIL miss_asid_fields got idx=%0d ppn=%h ps=%0d want 0 0 0", s_index[9:5], s_ppn[39:20], s_ps[11:6]);
    end
    tick();
    n_checks++;
    if (s_valid !== 2'b00 || s_index[4:0] !== 5'd5 || s_ppn[19:0] !== 20'hB) begin
      n_fail++; $display("FAIL hold_when_idle got valid=%b idx=%0d ppn=%h want 00 5 B", s_valid, s_index[4:0], s_ppn[19:0]);
    end
    set_port(0, 19'h12345, 1'b0, 10'd3);
    tick();
    s_req = '0;
    n_checks++;
    if (s_found[0] !== 1'b1 || s_ppn[19:0] !== 20'hA || s_d[0] !== 1'b1) begin
      n_fail++; $display("FAIL hit_even got found=%b ppn=%h d=%b want 1 A 1", s_found[0], s_ppn[19:0], s_d[0]);
    end
    // same-cycle write: read and search must both see the old ppn1
    set_port(0, 19'h12345, 1'b1, 10'd3);
    we = 1'b1; w_index = 5'd5; w_fill = 1'b0;
    w_entry = make_ent(19'h12345, 10'd3, 1'b0, PS_4K, 1'b1, 20'hA, 20'hC);
    r_index = 5'd5;
    #1;
    rd = tlb_ent_t'(r_entry);
    n_checks++;
    if (rd.p1.ppn !== 20'hB) begin n_fail++; $display("FAIL rd_prewrite got %h want B", rd.p1.ppn); end
    @(posedge clk); #1;
    we = 1'b0; s_req = '0;
    rd = tlb_ent_t'(r_entry);
    n_checks++;
    if (s_ppn[19:0] !== 20'hB || rd.p1.ppn !== 20'hC) begin
      n_fail++; $display("FAIL search_prewrite got search_ppn=%h rd_ppn=%h want B C", s_ppn[19:0], rd.p1.ppn);
    end
  endtask

  task automatic test_huge_multi();
    write_ent(5'd7, make_ent(19'h40000, 10'd9, 1'b1, 6'd21, 1'b1, 20'h70, 20'h71), 1'b0);
    set_port(1, 19'h40155, 1'b0, 10'd0);
    tick();
    s_req = '0;
    n_checks++;
    if (s_found[1] !== 1'b1 || s_index[9:5] !== 5'd7 || s_ppn[39:20] !== 20'h71 || s_multi[1] !== 1'b0 || s_ps[11:6] !== 6'd21) begin
      n_fail++; $display("FAIL huge_hit got found=%b idx=%0d ppn=%h multi=%b ps=%0d want 1 7 71 0 21",
                         s_found[1], s_index[9:5], s_ppn[39:20], s_multi[1], s_ps[11:6]);
    end
    write_ent(5'd2, make_ent(19'h40000, 10'd9, 1'b1, 6'd21, 1'b1, 20'h20, 20'h21), 1'b0);
    write_ent(5'd9, make_ent(19'h11111, 10'd3, 1'b0, PS_4K, 1'b1, 20'h90, 20'h91), 1'b0);
    set_port(1, 19'h40155, 1'b0, 10'd0);
    tick();
    s_req = '0;
    n_checks++;
    if (s_found[1] !== 1'b1 || s_index[9:5] !== 5'd2 || s_ppn[39:20] !== 20'h21 || s_multi[1] !== 1'b1) begin
      n_fail++; $display("FAIL multi_hit got found=%b idx=%0d ppn=%h multi=%b want 1 2 21 1",
                         s_found[1], s_index[9:5], s_ppn[39:20], s_multi[1]);
    end
  endtask

  task automatic test_invtlb();
    int cyc;
    inv_req = 1'b1; inv_op = 5'd5; inv_asid = 10'd3; inv_vpn = 19'h12345;
    tick();
    cyc = 1;
    inv_op = 5'd0;
    n_checks++;
    if (inv_busy !== 1'b1) begin n_fail++; $display("FAIL inv_busy_after_accept got %b want 1", inv_busy); end
    tick();
    cyc = 2;
    inv_req = 1'b0;
    while (!inv_done && cyc < 20) begin tick(); cyc++; end
    n_checks++;
    if (cyc !== 5 || inv_err !== 1'b0) begin
      n_fail++; $display("FAIL inv_latency got cycles=%0d err=%b want 5 0", cyc, inv_err);
    end
    tick();
    n_checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin
      n_fail++; $display("FAIL inv_no_requeue got busy=%b done=%b want 0 0", inv_busy, inv_done);
    end
    r_index = 5'd5; #1; rd = tlb_ent_t'(r_entry);
    n_checks++;
    if (rd.e !== 1'b0) begin n_fail++; $display("FAIL inv_idx5_cleared got e=%b want 0", rd.e); end
    r_index = 5'd7; #1; rd = tlb_ent_t'(r_entry);
    n_checks++;
    if (rd.e !== 1'b1) begin n_fail++; $display("FAIL inv_idx7_kept got e=%b want 1", rd.e); end
    set_port(0, 19'h12345, 1'b1, 10'd3);
    set_port(1, 19'h11111, 1'b0, 10'd3);
    tick();
    s_req = '0;
    n_checks++;
    if (s_found !== 2'b10 || s_index[9:5] !== 5'd9 || s_ppn[39:20] !== 20'h90) begin
      n_fail++; $display("FAIL inv_post_search got found=%b idx1=%0d ppn1=%h want 10 9 90", s_found, s_index[9:5], s_ppn[39:20]);
    end
  endtask

  task automatic test_inv_err();
    inv_req = 1'b1; inv_op = 5'd7;
    tick();
    inv_req = 1'b0;
    n_checks++;
    if (inv_done !== 1'b1 || inv_err !== 1'b1 || inv_busy !== 1'b1) begin
      n_fail++; $display("FAIL inv_err_pulse got done=%b err=%b busy=%b want 1 1 1", inv_done, inv_err, inv_busy);
    end
    tick();
    n_checks++;
    if (inv_done !== 1'b0 || inv_err !== 1'b0 || inv_busy !== 1'b0) begin
      n_fail++; $display("FAIL inv_err_end got done=%b err=%b busy=%b want 0 0 0", inv_done, inv_err, inv_busy);
    end
    r_index = 5'd9; #1; rd = tlb_ent_t'(r_entry);
    n_checks++;
    if (rd.e !== 1'b1) begin n_fail++; $display("FAIL inv_err_no_change got e=%b want 1", rd.e); end
  endtask

  task automatic test_reset_sweep();
    logic saw_done;
    inv_req = 1'b1; inv_op = 5'd3;
    tick();
    inv_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (inv_busy !== 1'b0 || inv_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_sweep_idle got busy=%b done=%b want 0 0", inv_busy, inv_done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inv_done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_sweep_no_done got %b want 0", saw_done); end
    set_port(0, 19'h11111, 1'b0, 10'd3);
    set_port(1, 19'h40155, 1'b0, 10'd0);
    tick();
    s_req = '0;
    n_checks++;
    if (s_valid !== 2'b11 || s_found !== 2'b00 || fill_idx !== 5'd0) begin
      n_fail++; $display("FAIL rst_sweep_all_miss got valid=%b found=%b fill=%0d want 11 00 0", s_valid, s_found, fill_idx);
    end
  endtask

  initial begin
    rst = 1'b1; s_req = '0; s_vppn = '0; s_odd = '0; s_asid = '0;
    we = 1'b0; w_fill = 1'b0; w_index = '0; w_entry = '0; r_index = '0;
    inv_req = 1'b0; inv_op = '0; inv_asid = '0; inv_vpn = '0;
    test_reset();
    test_fill();
    test_basic_hit();
    test_huge_multi();
    test_invtlb();
    test_inv_err();
    test_reset_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
